// File: rtl/coin_intake_ctrl.sv
// ---------------------------------------------------------------------------
// coin_intake_ctrl
//
// Purpose:
//   Turns the four coin beam-break sensors (1c, 5c, 10c, 25c) into coin
//   events for the CPU. Each raw sensor level is synchronised and debounced.
//   A per-channel FSM emits exactly one event per coin. Simultaneous events
//   are arbitrated into a small event FIFO, and a saturating cents total is
//   kept. The CPU sees a 4-word MMIO register window.
//
// Ports:
//   clock     in   1   system clock, all logic on posedge
//   reset     in   1   asynchronous, active-high; clears all state
//   beam_n    in   4   raw sensor levels, low = beam broken
//                      [0]=1c [1]=5c [2]=10c [3]=25c
//   rd_en     in   1   CPU read strobe for this window
//   wr_en     in   1   CPU write strobe for this window
//   addr      in   2   register select (0 STATUS, 1 EVENT, 2 TOTAL, 3 CTRL)
//   wdata     in  32   write data
//   rdata     out 32   read data, combinational from addr and state
//   coin_irq  out  1   high while the event FIFO is non-empty
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a level must be stable before acceptance (>= 2)
//   FIFO_DEPTH       event FIFO entries, power of 2 in 2..64
//   TOTAL_W          width of the cents accumulator
//
// Optional feature (macro COIN_TIMESTAMP_EN):
//   When defined, a 16-bit millisecond counter (one tick every
//   DEBOUNCE_CYCLES clocks) is stamped into event bits [31:16] at grant
//   time. STATUS bits [31:16] return the live counter. When undefined, no
//   counter exists and those bits read 0.
// ---------------------------------------------------------------------------
module coin_intake_ctrl #(
  parameter int DEBOUNCE_CYCLES = 30000,
  parameter int FIFO_DEPTH      = 8,
  parameter int TOTAL_W         = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  beam_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        coin_irq
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND_BRK,
    ST_BROKEN,
    ST_PEND_CLR
  } chan_state_t;

  // Synchroniser
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;

  // Channel FSMs
  chan_state_t      state_q [4];
  chan_state_t      state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [3:0]       confirm;

  // Arbiter
  logic [3:0] pend_q, pend_d;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic [4:0] event_value;
  logic [31:0] event_word;
  logic [15:0] ts_value;

  // FIFO and totals
  logic [31:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]  count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [TOTAL_W:0]   total_sum;
  logic [TOTAL_W-1:0] total_sat;
  logic               irq_q, irq_d;

  logic fifo_empty;
  logic fifo_full;
  logic ctrl_clear;
  logic pop;
  logic accept;
  logic push;

  // Only wdata[0] carries meaning; the rest is intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:1];

  // -------------------------------------------------------------------------
  // Input synchroniser
  // -------------------------------------------------------------------------
  always_comb begin
    sync1_d = beam_n;
    sync2_d = sync1_q;
  end

  // Reset to "beam clear" so leaving reset never looks like a break.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel debounce FSMs. The counter restarts on every state change;
  // confirm pulses once on the PEND_BRK -> BROKEN transition only.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      confirm[c] = 1'b0;
      unique case (state_q[c])
        ST_IDLE: begin
          cnt_d[c] = '0;
          if (!sync2_q[c]) begin
            state_d[c] = ST_PEND_BRK;
          end
        end
        ST_PEND_BRK: begin
          if (sync2_q[c]) begin
            state_d[c] = ST_IDLE;
            cnt_d[c]   = '0;
          end else if (cnt_q[c] == DB_LAST) begin
            state_d[c] = ST_BROKEN;
            cnt_d[c]   = '0;
            confirm[c] = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + 1'b1;
          end
        end
        ST_BROKEN: begin
          cnt_d[c] = '0;
          if (sync2_q[c]) begin
            state_d[c] = ST_PEND_CLR;
          end
        end
        ST_PEND_CLR: begin
          if (!sync2_q[c]) begin
            state_d[c] = ST_BROKEN;
            cnt_d[c]   = '0;
          end else if (cnt_q[c] == DB_LAST) begin
            state_d[c] = ST_IDLE;
            cnt_d[c]   = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + 1'b1;
          end
        end
        default: begin
          state_d[c] = ST_IDLE;
          cnt_d[c]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Fixed-priority arbiter: lowest pending index wins. Un-granted flags are
  // held, and a fresh confirm simply ORs into its flag (merge).
  // -------------------------------------------------------------------------
  always_comb begin
    grant_idx = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (pend_q[c]) begin
        grant_idx = 2'(c);
      end
    end
    grant_valid = |pend_q;
    grant       = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;
    pend_d      = (pend_q & ~grant) | confirm;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    unique case (grant_idx)
      2'd0:    event_value = 5'd1;
      2'd1:    event_value = 5'd5;
      2'd2:    event_value = 5'd10;
      default: event_value = 5'd25;
    endcase
  end

  // -------------------------------------------------------------------------
  // Optional millisecond timestamp
  // -------------------------------------------------------------------------
`ifdef COIN_TIMESTAMP_EN
  logic [CNT_W-1:0] pre_q, pre_d;
  logic [15:0]      ms_q, ms_d;

  always_comb begin
    pre_d = pre_q + 1'b1;
    ms_d  = ms_q;
    if (pre_q == DB_LAST) begin
      pre_d = '0;
      ms_d  = ms_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= pre_d;
      ms_q  <= ms_d;
    end
  end

  assign ts_value = ms_q;
`else
  assign ts_value = 16'd0;
`endif

  assign event_word = {ts_value, 6'd0, grant_idx, 3'd0, event_value};

  // -------------------------------------------------------------------------
  // FIFO, overflow and total. A clear beats any grant or pop in the same
  // cycle. On a full FIFO a simultaneous pop makes room, so the push lands.
  // -------------------------------------------------------------------------
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL);
  assign ctrl_clear = wr_en && (addr == 2'd3) && wdata[0];
  assign pop        = rd_en && (addr == 2'd1) && !fifo_empty && !ctrl_clear;
  assign accept     = grant_valid && !ctrl_clear;
  assign push       = accept && (!fifo_full || pop);

  assign total_sum = {1'b0, total_q} + (TOTAL_W + 1)'(event_value);
  assign total_sat = total_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : total_sum[TOTAL_W-1:0];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    total_d    = total_q;
    if (ctrl_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      total_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + FCNT_W'(push) - FCNT_W'(pop);
      if (accept && !push) begin
        overflow_d = 1'b1;
      end
      if (accept) begin
        total_d = total_sat;
      end
    end
    irq_d = (count_d != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      total_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      total_q    <= total_d;
      irq_q      <= irq_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= event_word;
    end
  end

  assign coin_irq = irq_q;

  // -------------------------------------------------------------------------
  // Register read mux
  // -------------------------------------------------------------------------
  always_comb begin
    rdata = 32'd0;
    unique case (addr)
      2'd0:    rdata = {ts_value, 5'd0, overflow_q, fifo_full, fifo_empty, 8'(count_q)};
      2'd1:    rdata = fifo_empty ? 32'd0 : fifo_mem[rd_ptr_q];
      2'd2:    rdata = 32'(total_q);
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_coin_intake_ctrl.sv
// Directed bench for coin_intake_ctrl. A second instance with an 8-bit
// accumulator shares all stimulus so the saturating total can be observed.
module tb_coin_intake_ctrl;

  localparam int DB    = 10;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  beam_n;
  logic        rd_en;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] rdata8;
  logic        coin_irq;
  logic        coin_irq8;

  int total_checks = 0;
  int bad_checks   = 0;

  logic [31:0] rd;
  logic [31:0] rd8;
  logic        irq_seen;
  logic        found;

  coin_intake_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .FIFO_DEPTH     (DEPTH),
    .TOTAL_W        (16)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .beam_n  (beam_n),
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .coin_irq(coin_irq)
  );

  coin_intake_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .FIFO_DEPTH     (DEPTH),
    .TOTAL_W        (8)
  ) dut8 (
    .clock   (clock),
    .reset   (reset),
    .beam_n  (beam_n),
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata8),
    .coin_irq(coin_irq8)
  );

  always #5 clock = ~clock;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive a sensor pattern and hold it for n clocks.
  task automatic applyStimulus(input logic [3:0] pattern, input int n);
    @(negedge clock);
    beam_n = pattern;
    repeat (n) @(posedge clock);
  endtask

  // One-cycle read access; EVENT reads pop on the following posedge.
  task automatic busRead(input logic [1:0] a, output logic [31:0] d,
                         output logic [31:0] d8);
    @(negedge clock);
    addr  = a;
    rd_en = 1'b1;
    #1;
    d  = rdata;
    d8 = rdata8;
    @(posedge clock);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    @(negedge clock);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    wdata = 32'd0;
  endtask

  // Full coin passage: beam broken long enough, then clear long enough.
  task automatic dropCoin(input logic [3:0] pattern);
    applyStimulus(pattern, 3 * DB);
    applyStimulus(4'hF, 2 * DB);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    beam_n = 4'hF;
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    addr   = 2'd1;
    wdata  = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_irq", {31'd0, coin_irq}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    busRead(2'd0, rd, rd8);
    checkOutput("rst_status", rd, 32'h100);
    busRead(2'd2, rd, rd8);
    checkOutput("rst_total", rd, 32'd0);

    // Popping an empty FIFO returns 0 and changes nothing.
    busRead(2'd1, rd, rd8);
    checkOutput("empty_pop", rd, 32'd0);
    busRead(2'd0, rd, rd8);
    checkOutput("empty_pop_status", rd, 32'h100);

    // Single 10c coin, held for 3 debounce periods.
    dropCoin(4'b1011);
    busRead(2'd0, rd, rd8);
    checkOutput("dime_status", rd, 32'h001);
    checkOutput("dime_irq", {31'd0, coin_irq}, 32'd1);
    busRead(2'd1, rd, rd8);
    checkOutput("dime_event", rd, 32'h20A);
    busRead(2'd0, rd, rd8);
    checkOutput("dime_status_after", rd, 32'h100);
    busRead(2'd2, rd, rd8);
    checkOutput("dime_total", rd, 32'd10);
    checkOutput("dime_irq_after", {31'd0, coin_irq}, 32'd0);

    busWrite(2'd3, 32'd1);
    busRead(2'd2, rd, rd8);
    checkOutput("clear_total", rd, 32'd0);

    // 1c glitch shorter than the debounce window.
    irq_seen = 1'b0;
    @(negedge clock);
    beam_n = 4'b1110;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (i == 4) beam_n = 4'hF;
      irq_seen = irq_seen | coin_irq;
    end
    checkOutput("glitch_irq", {31'd0, irq_seen}, 32'd0);
    busRead(2'd0, rd, rd8);
    checkOutput("glitch_status", rd, 32'h100);
    busRead(2'd2, rd, rd8);
    checkOutput("glitch_total", rd, 32'd0);

    // All four sensors break together: count must step 1,2,3,4.
    @(negedge clock);
    beam_n = 4'b0000;
    addr   = 2'd0;
    found  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!found) begin
        @(negedge clock);
        #1;
        if (rdata[7:0] != 8'd0) found = 1'b1;
      end
    end
    checkOutput("burst_seen", {31'd0, found}, 32'd1);
    checkOutput("burst_cnt1", {24'd0, rdata[7:0]}, 32'd1);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clock);
      #1;
      checkOutput($sformatf("burst_cnt%0d", k), {24'd0, rdata[7:0]}, 32'(k));
    end
    applyStimulus(4'b0000, 2 * DB);
    applyStimulus(4'hF, 2 * DB);
    busRead(2'd1, rd, rd8);
    checkOutput("burst_ev0", rd, 32'h001);
    busRead(2'd1, rd, rd8);
    checkOutput("burst_ev1", rd, 32'h105);
    busRead(2'd1, rd, rd8);
    checkOutput("burst_ev2", rd, 32'h20A);
    busRead(2'd1, rd, rd8);
    checkOutput("burst_ev3", rd, 32'h319);
    busRead(2'd2, rd, rd8);
    checkOutput("burst_total", rd, 32'd41);
    checkOutput("burst_total8", rd8, 32'd41);

    // Clear with three 5c events queued; ignored writes first.
    busWrite(2'd3, 32'd1);
    for (int i = 0; i < 3; i++) dropCoin(4'b1101);
    busRead(2'd0, rd, rd8);
    checkOutput("nickel_status", rd, 32'h003);
    busRead(2'd2, rd, rd8);
    checkOutput("nickel_total", rd, 32'd15);
    busWrite(2'd3, 32'd0);
    busWrite(2'd2, 32'd1);
    busRead(2'd0, rd, rd8);
    checkOutput("ignored_wr_status", rd, 32'h003);
    busRead(2'd2, rd, rd8);
    checkOutput("ignored_wr_total", rd, 32'd15);
    busWrite(2'd3, 32'd1);
    busRead(2'd0, rd, rd8);
    checkOutput("ctrl_clear_status", rd, 32'h100);
    busRead(2'd2, rd, rd8);
    checkOutput("ctrl_clear_total", rd, 32'd0);
    checkOutput("ctrl_clear_irq", {31'd0, coin_irq}, 32'd0);

    // Reset while a 25c break is still being debounced.
    applyStimulus(4'b0111, 6);
    @(negedge clock);
    reset  = 1'b1;
    beam_n = 4'hF;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (3 * DB) @(posedge clock);
    busRead(2'd0, rd, rd8);
    checkOutput("midrst_status", rd, 32'h100);
    busRead(2'd2, rd, rd8);
    checkOutput("midrst_total", rd, 32'd0);

    // FIFO_DEPTH+2 quarters, no reads.
    for (int i = 0; i < DEPTH + 2; i++) dropCoin(4'b0111);
    busRead(2'd0, rd, rd8);
    checkOutput("ovf_status", rd, 32'h608);
    busRead(2'd2, rd, rd8);
    checkOutput("ovf_total", rd, 32'(25 * (DEPTH + 2)));
    checkOutput("ovf_total8", rd8, 32'(25 * (DEPTH + 2)));
    checkOutput("ovf_irq", {31'd0, coin_irq}, 32'd1);

    // 11th quarter: pop on the exact grant cycle. The grant pushes on the
    // posedge DB+4 clocks after the input change (2 sync, 1 idle, DB
    // debounce, 1 arbiter).
    @(negedge clock);
    beam_n = 4'b0111;
    repeat (DB + 3) @(negedge clock);
    addr  = 2'd1;
    rd_en = 1'b1;
    #1;
    checkOutput("pop_grant_head", rdata, 32'h319);
    @(posedge clock);
    #1;
    rd_en = 1'b0;
    addr  = 2'd0;
    @(negedge clock);
    #1;
    checkOutput("pop_grant_status", rdata, 32'h608);
    applyStimulus(4'b0111, 2 * DB);
    applyStimulus(4'hF, 2 * DB);
    busRead(2'd2, rd, rd8);
    checkOutput("final_total", rd, 32'd275);
    checkOutput("sat_total8", rd8, 32'd255);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/coin_intake_ctrl.md
Name: coin_intake_ctrl

Overview:
Sequences the four coin beam-break sensors (1c, 5c, 10c, 25c) and publishes their events to the CPU through MMIO. Each raw sensor input is synchronised and debounced, and a per-channel FSM turns each confirmed beam break into exactly one coin event. The block arbitrates simultaneous coin events into a small event FIFO and keeps a running cents total. The CPU reads status, pops events and clears state through a 4-word register window in the MMIO decode.

Parameters:
DEBOUNCE_CYCLES, 30000, cycles a sensor level must be stable before it is accepted (1 ms at 30 MHz); must be >= 2
FIFO_DEPTH, 8, event FIFO entries; power of 2, 2..64
TOTAL_W, 16, width of the cents accumulator

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state
beam_n  in  4  raw sensor levels, low = beam broken; [0]=1c [1]=5c [2]=10c [3]=25c; asynchronous to clock
rd_en  in  1  CPU read strobe for this window, one cycle per access
wr_en  in  1  CPU write strobe for this window
addr  in  2  register select within the window
wdata  in  32  write data
rdata  out  32  read data; combinational from addr and current state
coin_irq  out  1  high while the FIFO is non-empty

Behaviour:
- Reset values: rdata=0, coin_irq=0, FIFO empty, total=0, overflow=0, all channel FSMs in IDLE, debounce counters=0, arbiter pending flags=0.
- Input path: each beam_n bit passes through a 2-flop synchroniser, giving 2 cycles of input latency.
- Per-channel FSM:
  - IDLE -> PEND_BRK when the synchronised input is 0.
  - PEND_BRK counts while the input stays 0. If the input returns to 1 before DEBOUNCE_CYCLES, go back to IDLE with no event. On reaching DEBOUNCE_CYCLES, go to BROKEN and set the channel pending flag.
  - BROKEN -> PEND_CLR when the input is 1.
  - PEND_CLR returns to BROKEN if the input drops back to 0 before DEBOUNCE_CYCLES, otherwise goes to IDLE.
  - Counters reset on every state entry. A coin that stays in the beam produces one event only.
- Arbiter:
  - Each cycle, the lowest-index pending flag is granted and cleared, and one event is pushed.
  - Pending flags not granted are held, so no event is lost. Four simultaneous events drain in 4 consecutive cycles.
  - A new confirm on a channel whose flag is still pending merges with it and is counted once. This is impossible when DEBOUNCE_CYCLES >= 4.
- Event word: [4:0] value in cents (1/5/10/25), [9:8] channel index, [31:16] per the optional feature, all other bits 0.
- Totalling on each grant:
  - total += value, saturating at 2^TOTAL_W-1.
  - If the FIFO is full, the event is dropped and overflow is set (sticky); total is still updated.
  - When a push and a pop occur in the same cycle on a full FIFO, the pop is applied first and the push is accepted.
- Register map (reads):
  - addr 0 STATUS: [7:0] FIFO count, [8] empty, [9] full, [10] overflow.
  - addr 1 EVENT: returns the head entry and pops it on rd_en. When empty it returns 0 and nothing changes.
  - addr 2 TOTAL: zero-extended total.
  - addr 3: reads 0.
- Register map (writes):
  - addr 3 CTRL with wdata[0]=1 clears the FIFO, total and overflow in one cycle.
  - A grant in the same cycle as a clear is discarded.
  - Channel FSMs are unaffected by a clear.
  - Writes to other addresses are ignored.
- Reset mid-debounce: asynchronous return to IDLE, no event emitted after reset.
- coin_irq = !empty, registered with the FIFO state.

Optional Feature:
COIN_TIMESTAMP_EN
- Defined: a 16-bit millisecond counter (prescaler of DEBOUNCE_CYCLES clocks, wraps at 65535) is reset to 0. Its value at grant time is stored in event bits [31:16]. STATUS bits [31:16] return the live counter.
- Undefined: no counter logic exists and those bits read 0.

Test Plan:
- beam_n[2] low for 3*DEBOUNCE_CYCLES then high -> exactly one event; EVENT read = 0x20A, TOTAL=10, STATUS count 1 before the read and 0 after it.
- beam_n[0] low for DEBOUNCE_CYCLES-5 then high (glitch) -> no event, TOTAL=0, coin_irq stays 0.
- All four beam_n bits fall in the same cycle and are held -> 4 events pushed on consecutive cycles in order 1c, 5c, 10c, 25c; TOTAL=41.
- FIFO_DEPTH+2 coins on channel 3 with no reads -> count=FIFO_DEPTH, full=1, overflow=1, TOTAL=25*(FIFO_DEPTH+2); pop while a grant occurs -> count stays FIFO_DEPTH.
- Write CTRL=1 with 3 events queued and TOTAL=15 -> STATUS=0x100 (empty), TOTAL=0; assert reset mid-PEND_BRK -> no event after release.
- Total saturation with TOTAL_W=8: 11 quarters -> TOTAL=255.
